// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding types: format enum, base opcodes, canonical NOP, packed field bundle.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_LOAD   = 3'd0,
    FMT_OP_IMM = 3'd1,
    FMT_STORE  = 3'd2,
    FMT_BRANCH = 3'd3,
    FMT_OP     = 3'd4
  } enc_fmt_t;

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    enc_fmt_t    fmt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational fields -> RV32I word packer. INST_ENC_RANGE_CHECK_EN adds immediate range /
// illegal-format flagging on err_o; otherwise err_o is 0 and fields are silently truncated.
module inst_pack
  import riscv_enc_pkg::*;
(
  input  enc_fields_t fields_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  logic [31:0] imm;
  logic        is_shift;

  assign imm      = fields_i.imm;
  assign is_shift = (fields_i.funct3 == 3'b001) || (fields_i.funct3 == 3'b101);

  always_comb begin
    word_o = NOP_INST;
    case (fields_i.fmt)
      FMT_LOAD:   word_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, OPC_LOAD};
      FMT_OP_IMM: word_o = is_shift
                    ? {fields_i.funct7, imm[4:0], fields_i.rs1, fields_i.funct3, fields_i.rd, OPC_OP_IMM}
                    : {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, OPC_OP_IMM};
      FMT_STORE:  word_o = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0], OPC_STORE};
      FMT_BRANCH: word_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                            imm[4:1], imm[11], OPC_BRANCH};
      FMT_OP:     word_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                            fields_i.rd, OPC_OP};
      default:    word_o = NOP_INST;
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // A value fits an N-bit signed field iff all bits from N-1 upward agree with the sign.
  logic fits12, fits13;
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);

  always_comb begin
    err_o = 1'b1;
    case (fields_i.fmt)
      FMT_LOAD, FMT_STORE: err_o = !fits12;
      FMT_OP_IMM:          err_o = is_shift ? (imm[31:5] != '0) : !fits12;
      FMT_BRANCH:          err_o = imm[0] || !fits13;
      FMT_OP:              err_o = 1'b0;
      default:             err_o = 1'b1;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:13];
  assign err_o         = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// 2-stage valid/ready RV32I instruction encoder with issued-word counter.
// Optional immediate range checking via INST_ENC_RANGE_CHECK_EN (see inst_pack).
module inst_encoder
  import riscv_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  enc_fields_t      in_fields, s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_inst_q, out_inst_d, pack_word;
  logic             out_err_q, out_err_d, pack_err;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_adv, s1_adv;

  assign in_fields = '{fmt: enc_fmt_t'(in_fmt), funct3: in_funct3, funct7: in_funct7,
                       rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;

  inst_pack u_pack (
    .fields_i (s1_q),
    .word_o   (pack_word),
    .err_o    (pack_err)
  );

  // S1 refills whenever it is free or draining; S2 holds its word while stalled.
  always_comb begin
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s1_d        = (in_ready && in_valid) ? in_fields : s1_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    out_inst_d  = s1_adv ? pack_word : out_inst_q;
    out_err_d   = s1_adv ? pack_err : out_err_q;
    cnt_d       = (out_valid_q && out_ready) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign enc_count = cnt_q;

endmodule
